terrain_scheduler: RTL and testbench
====================================

TERRAIN_SCHEDULER -- requirements
Module: terrain_scheduler

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- NUM_SLOTS, 4, number of terrain segment slots
- SPAWN_PERIOD, 60, active frames between automatic spawns
- SPAWN_X, 180, x loaded on spawn
- SPAWN_Y, 360, y loaded on spawn
- X_LIMIT, 1280, retire when x >= X_LIMIT
- Y_LIMIT, 720, retire when y >= Y_LIMIT
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- i_clk, in, 1, sole clock, all state on rising edge
- i_rst, in, 1, synchronous active-high reset
- i_v_sync, in, 1, frame sync level, asynchronous to i_clk
- i_active, in, 1, enable for motion and spawning
- i_spawn_req, in, 1, one-cycle request for an extra spawn
- o_slot_x, out, 16*NUM_SLOTS, slot k x position at bits [16k+15:16k]
- o_slot_y, out, 16*NUM_SLOTS, slot k y position, same packing
- o_slot_valid, out, NUM_SLOTS, slot k drawable
- o_frame_tick, out, 1, one-cycle pulse per detected frame
- o_spawn_ack, out, 1, one-cycle pulse when a slot is loaded
- o_busy, out, 1, high whenever the FSM is not in IDLE
- o_overflow, out, 1, sticky: spawn pending with no free slot, or tick missed while busy

Function
REQ-003 i_v_sync SHALL pass through a 2-flop synchroniser; rising edge = sync2 & ~sync2_d.
REQ-004 o_frame_tick SHALL be registered and high for exactly one cycle, starting 3 edges after the edge first sampling i_v_sync high.
REQ-005 FSM states SHALL be IDLE, UPDATE, SPAWN.
REQ-006 IDLE -> UPDATE with idx=0 on a detected edge when i_active=1; otherwise remain IDLE.
REQ-007 In UPDATE, slot idx only SHALL be processed once per cycle, idx incrementing by 1; after idx=NUM_SLOTS-1, go to SPAWN.
REQ-008 Processing a valid slot: if pre-update x >= X_LIMIT or y >= Y_LIMIT, clear valid; else x <= x-1, y <= y+1 (16-bit, modulo 2^16). Invalid slots are unchanged.
REQ-009 x decrement wraps 0 -> 65535; the next frame then retires that slot.
REQ-010 Spawn timer (0..SPAWN_PERIOD-1) SHALL increment on each edge accepted in IDLE; on passing SPAWN_PERIOD-1 it SHALL wrap to 0 and set spawn_pending.
REQ-011 i_spawn_req=1 in any state SHALL set spawn_pending. Multiple requests before service merge into one.
REQ-012 In SPAWN with spawn_pending=1, the lowest-index invalid slot SHALL be loaded with (SPAWN_X, SPAWN_Y) and made valid. spawn_pending clears and o_spawn_ack pulses on the same edge.
REQ-013 SPAWN with no free slot SHALL keep spawn_pending, set o_overflow, and not pulse o_spawn_ack.
REQ-014 i_spawn_req in the same cycle as the SPAWN service SHALL leave spawn_pending=1.
REQ-015 SPAWN -> IDLE unconditionally after one cycle. Frame processing latency SHALL be NUM_SLOTS+1 cycles.
REQ-016 An edge detected while not IDLE SHALL be dropped and set o_overflow; o_frame_tick still pulses.
REQ-017 i_active is sampled only at IDLE exit. Deassertion mid-frame does not abort the frame.

Reset
REQ-018 i_rst=1 at any edge SHALL force:
- state IDLE, idx 0, timer 0, spawn_pending 0
- synchroniser flops 0
- all o_slot_valid 0, all positions 0
- o_frame_tick, o_spawn_ack, o_busy, o_overflow 0
Reset mid-frame aborts the frame immediately.

Verification
REQ-019 Reset, i_active=1, 60 vsync pulses -> one o_spawn_ack; slot0 valid at (180,360).
REQ-020 Slot0 valid at (180,360), one more frame -> (179,361); o_busy high exactly 5 cycles.
REQ-021 Slot0 at (180,719) -> next frame (179,720); following frame valid=0, position held.
REQ-022 Four slots valid, i_spawn_req -> no ack, o_overflow=1. Retire slot2 -> next SPAWN loads slot2, ack pulses.
REQ-023 i_active=0 for 100 vsyncs -> positions, timer and valid bits frozen; o_frame_tick pulses 100 times.
REQ-024 i_rst asserted during UPDATE idx=2 -> next cycle all outputs 0, state IDLE; the next frame behaves as first-after-reset.

Source files
------------

// File: rtl/terrain_scheduler.sv
// Per-frame scheduler for a small pool of terrain segments: moves each live segment
// one step per detected vsync, retires off-screen segments and spawns new ones.
module terrain_scheduler #(
  parameter int NUM_SLOTS    = 4,
  parameter int SPAWN_PERIOD = 60,
  parameter int SPAWN_X      = 180,
  parameter int SPAWN_Y      = 360,
  parameter int X_LIMIT      = 1280,
  parameter int Y_LIMIT      = 720
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_v_sync,
  input  logic                   i_active,
  input  logic                   i_spawn_req,
  output logic [16*NUM_SLOTS-1:0] o_slot_x,
  output logic [16*NUM_SLOTS-1:0] o_slot_y,
  output logic [NUM_SLOTS-1:0]   o_slot_valid,
  output logic                   o_frame_tick,
  output logic                   o_spawn_ack,
  output logic                   o_busy,
  output logic                   o_overflow
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int TMR_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [15:0] X_LIM = 16'(X_LIMIT);
  localparam logic [15:0] Y_LIM = 16'(Y_LIMIT);
  localparam logic [15:0] X_SPAWN = 16'(SPAWN_X);
  localparam logic [15:0] Y_SPAWN = 16'(SPAWN_Y);

  typedef enum logic [1:0] {IDLE, UPDATE, SPAWN} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 pending_q, pending_d;
  logic [15:0]          x_q [NUM_SLOTS];
  logic [15:0]          x_d [NUM_SLOTS];
  logic [15:0]          y_q [NUM_SLOTS];
  logic [15:0]          y_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] valid_q, valid_d;
  logic                 ack_q, ack_d;
  logic                 ovf_q, ovf_d;
  logic                 sync1_q, sync2_q, sync2_dly_q;
  logic                 rise_q, tick_q;
  logic                 rise;
  logic                 free_found;
  logic [IDX_W-1:0]     free_idx;

  assign rise = sync2_q & ~sync2_dly_q;

  // Lowest-index free slot; scanning downward lets the lowest index win.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (!valid_q[k]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(k);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    pending_d = pending_q;
    x_d       = x_q;
    y_d       = y_q;
    valid_d   = valid_q;
    ack_d     = 1'b0;
    ovf_d     = ovf_q;

    case (state_q)
      IDLE: begin
        if (rise && i_active) begin
          state_d = UPDATE;
          idx_d   = '0;
          if (timer_q == TMR_W'(SPAWN_PERIOD - 1)) begin
            timer_d   = '0;
            pending_d = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      UPDATE: begin
        // Retirement tests the pre-update position, so a wrapped x lives one frame.
        if (valid_q[idx_q]) begin
          if (x_q[idx_q] >= X_LIM || y_q[idx_q] >= Y_LIM) begin
            valid_d[idx_q] = 1'b0;
          end else begin
            x_d[idx_q] = x_q[idx_q] - 16'd1;
            y_d[idx_q] = y_q[idx_q] + 16'd1;
          end
        end
        if (idx_q == IDX_W'(NUM_SLOTS - 1)) begin
          state_d = SPAWN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      SPAWN: begin
        state_d = IDLE;
        if (pending_q) begin
          if (free_found) begin
            x_d[free_idx]     = X_SPAWN;
            y_d[free_idx]     = Y_SPAWN;
            valid_d[free_idx] = 1'b1;
            pending_d         = 1'b0;
            ack_d             = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (rise && state_q != IDLE) ovf_d = 1'b1;
    // A request on the service edge outranks the clear, so it is never lost.
    if (i_spawn_req) pending_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      timer_q     <= '0;
      pending_q   <= 1'b0;
      x_q         <= '{default: '0};
      y_q         <= '{default: '0};
      valid_q     <= '0;
      ack_q       <= 1'b0;
      ovf_q       <= 1'b0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync2_dly_q <= 1'b0;
      rise_q      <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      pending_q   <= pending_d;
      x_q         <= x_d;
      y_q         <= y_d;
      valid_q     <= valid_d;
      ack_q       <= ack_d;
      ovf_q       <= ovf_d;
      sync1_q     <= i_v_sync;
      sync2_q     <= sync1_q;
      sync2_dly_q <= sync2_q;
      rise_q      <= rise;
      tick_q      <= rise_q;
    end
  end

  always_comb begin
    o_slot_x = '0;
    o_slot_y = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      o_slot_x[16*k +: 16] = x_q[k];
      o_slot_y[16*k +: 16] = y_q[k];
    end
  end

  assign o_slot_valid = valid_q;
  assign o_frame_tick = tick_q;
  assign o_spawn_ack  = ack_q;
  assign o_busy       = (state_q != IDLE);
  assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_terrain_scheduler.sv
// Directed bench for terrain_scheduler: a default instance plus one spawning at y=719.
module tb_terrain_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v_sync = 1'b0;
  logic        active = 1'b0;
  logic        req = 1'b0;

  logic [63:0] a_x, a_y, b_x, b_y;
  logic [3:0]  a_valid, b_valid;
  logic        a_tick, a_ack, a_busy, a_ovf;
  logic        b_tick, b_ack, b_busy, b_ovf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  terrain_scheduler u_a (
    .i_clk(clk), .i_rst(rst), .i_v_sync(v_sync), .i_active(active), .i_spawn_req(req),
    .o_slot_x(a_x), .o_slot_y(a_y), .o_slot_valid(a_valid), .o_frame_tick(a_tick),
    .o_spawn_ack(a_ack), .o_busy(a_busy), .o_overflow(a_ovf)
  );

  terrain_scheduler #(.SPAWN_Y(719)) u_b (
    .i_clk(clk), .i_rst(rst), .i_v_sync(v_sync), .i_active(active), .i_spawn_req(req),
    .o_slot_x(b_x), .o_slot_y(b_y), .o_slot_valid(b_valid), .o_frame_tick(b_tick),
    .o_spawn_ack(b_ack), .o_busy(b_busy), .o_overflow(b_ovf)
  );

  // One 12-cycle frame: vsync high for 4 cycles, optional request at frame start
  // and/or on the SPAWN service edge. Observations are taken on negedges.
  task automatic run_frame(input bit do_req, input bit req_late,
                           output int tick_at, output int ticks, output int acks, output int busy_n);
    tick_at = -1; ticks = 0; acks = 0; busy_n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (a_tick) begin ticks++; if (tick_at < 0) tick_at = i; end
      if (a_ack) acks++;
      if (a_busy) busy_n++;
      v_sync = (i < 4);
      req = (i == 0 && do_req) || (i == 7 && req_late);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (a_valid !== 4'b0000 || b_valid !== 4'b0000) begin failures++;
      $display("FAIL reset_valid got a=%b b=%b exp 0000", a_valid, b_valid); end
    checks++; if (a_x !== 64'd0 || a_y !== 64'd0) begin failures++;
      $display("FAIL reset_pos got x=%h y=%h exp 0", a_x, a_y); end
    checks++; if ({a_tick, a_ack, a_busy, a_ovf} !== 4'b0000) begin failures++;
      $display("FAIL reset_status got %b exp 0000", {a_tick, a_ack, a_busy, a_ovf}); end
    rst = 1'b0;
    active = 1'b1;
  endtask

  task automatic test_spawn_timer();
    int ta, tk, ak, bn, bad_tick, early_ack, last_ack;
    bad_tick = 0; early_ack = 0; last_ack = 0;
    for (int f = 1; f <= 60; f++) begin
      run_frame(1'b0, 1'b0, ta, tk, ak, bn);
      if (ta != 4 || tk != 1) bad_tick++;
      if (f < 60) early_ack += ak; else last_ack = ak;
    end
    checks++; if (bad_tick != 0) begin failures++;
      $display("FAIL tick_timing got %0d bad frames exp 0", bad_tick); end
    checks++; if (early_ack != 0 || last_ack != 1) begin failures++;
      $display("FAIL timer_ack got early=%0d last=%0d exp 0/1", early_ack, last_ack); end
    checks++; if (a_valid !== 4'b0001 || a_x[15:0] !== 16'd180 || a_y[15:0] !== 16'd360) begin failures++;
      $display("FAIL timer_slot0 got v=%b (%0d,%0d) exp 0001 (180,360)", a_valid, a_x[15:0], a_y[15:0]); end
    checks++; if (b_valid !== 4'b0001 || b_y[15:0] !== 16'd719) begin failures++;
      $display("FAIL timer_slot0_b got v=%b y=%0d exp 0001 719", b_valid, b_y[15:0]); end
  endtask

  task automatic test_motion();
    int ta, tk, ak, bn;
    run_frame(1'b0, 1'b0, ta, tk, ak, bn);
    checks++; if (bn != 5) begin failures++;
      $display("FAIL busy_len got %0d exp 5", bn); end
    checks++; if (a_x[15:0] !== 16'd179 || a_y[15:0] !== 16'd361) begin failures++;
      $display("FAIL motion_a got (%0d,%0d) exp (179,361)", a_x[15:0], a_y[15:0]); end
    checks++; if (b_valid !== 4'b0001 || b_x[15:0] !== 16'd179 || b_y[15:0] !== 16'd720) begin failures++;
      $display("FAIL motion_b got v=%b (%0d,%0d) exp 0001 (179,720)", b_valid, b_x[15:0], b_y[15:0]); end
  endtask

  task automatic test_retire_y();
    int ta, tk, ak, bn;
    run_frame(1'b0, 1'b0, ta, tk, ak, bn);
    checks++; if (b_valid !== 4'b0000 || b_x[15:0] !== 16'd179 || b_y[15:0] !== 16'd720) begin failures++;
      $display("FAIL retire_y got v=%b (%0d,%0d) exp 0000 (179,720)", b_valid, b_x[15:0], b_y[15:0]); end
    checks++; if (a_valid !== 4'b0001 || a_x[15:0] !== 16'd178 || a_y[15:0] !== 16'd362) begin failures++;
      $display("FAIL retire_y_a got v=%b (%0d,%0d) exp 0001 (178,362)", a_valid, a_x[15:0], a_y[15:0]); end
  endtask

  task automatic test_inactive();
    int ta, tk, ak, bn, ticks, acks, busy, early_ack, last_ack;
    ticks = 0; acks = 0; busy = 0; early_ack = 0; last_ack = 0;
    active = 1'b0;
    for (int f = 0; f < 100; f++) begin
      run_frame(1'b0, 1'b0, ta, tk, ak, bn);
      ticks += tk; acks += ak; busy += bn;
    end
    checks++; if (ticks != 100) begin failures++;
      $display("FAIL inactive_ticks got %0d exp 100", ticks); end
    checks++; if (busy != 0 || acks != 0) begin failures++;
      $display("FAIL inactive_idle got busy=%0d acks=%0d exp 0/0", busy, acks); end
    checks++; if (a_valid !== 4'b0001 || a_x[15:0] !== 16'd178 || a_y[15:0] !== 16'd362) begin failures++;
      $display("FAIL inactive_frozen got v=%b (%0d,%0d) exp 0001 (178,362)", a_valid, a_x[15:0], a_y[15:0]); end
    // Timer stood at 2 before the pause, so the next spawn is 58 active frames away.
    active = 1'b1;
    for (int f = 1; f <= 58; f++) begin
      run_frame(1'b0, 1'b0, ta, tk, ak, bn);
      if (f < 58) early_ack += ak; else last_ack = ak;
    end
    checks++; if (early_ack != 0 || last_ack != 1) begin failures++;
      $display("FAIL timer_frozen got early=%0d last=%0d exp 0/1", early_ack, last_ack); end
  endtask

  task automatic test_mid_reset();
    int ta, tk, ak, bn;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      v_sync = (i < 4);
      rst = (i == 5);
    end
    @(negedge clk);
    checks++; if (a_valid !== 4'b0000 || b_valid !== 4'b0000) begin failures++;
      $display("FAIL midrst_valid got a=%b b=%b exp 0000", a_valid, b_valid); end
    checks++; if (a_x !== 64'd0 || a_y !== 64'd0) begin failures++;
      $display("FAIL midrst_pos got x=%h y=%h exp 0", a_x, a_y); end
    checks++; if ({a_tick, a_ack, a_busy, a_ovf} !== 4'b0000) begin failures++;
      $display("FAIL midrst_status got %b exp 0000", {a_tick, a_ack, a_busy, a_ovf}); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_frame(1'b0, 1'b0, ta, tk, ak, bn);
    checks++; if (ta != 4 || bn != 5 || ak != 0 || a_valid !== 4'b0000) begin failures++;
      $display("FAIL midrst_next got tick_at=%0d busy=%0d ack=%0d v=%b exp 4/5/0/0000", ta, bn, ak, a_valid); end
  endtask

  task automatic test_busy_drop();
    int ticks, busy;
    ticks = 0; busy = 0;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (a_tick) ticks++;
      if (a_busy) busy++;
      v_sync = (i == 0) || (i == 3);
    end
    checks++; if (ticks != 2 || busy != 5) begin failures++;
      $display("FAIL busy_drop got ticks=%0d busy=%0d exp 2/5", ticks, busy); end
    checks++; if (a_ovf !== 1'b1) begin failures++;
      $display("FAIL busy_drop_ovf got %b exp 1", a_ovf); end
  endtask

  task automatic test_spawn_collide();
    int ta, tk, ak, bn;
    do_reset();
    run_frame(1'b1, 1'b1, ta, tk, ak, bn);
    checks++; if (ak != 1 || a_valid !== 4'b0001) begin failures++;
      $display("FAIL collide_first got ack=%0d v=%b exp 1 0001", ak, a_valid); end
    run_frame(1'b0, 1'b0, ta, tk, ak, bn);
    checks++; if (ak != 1 || a_valid !== 4'b0011) begin failures++;
      $display("FAIL collide_kept got ack=%0d v=%b exp 1 0011", ak, a_valid); end
    run_frame(1'b0, 1'b0, ta, tk, ak, bn);
    checks++; if (ak != 0 || a_ovf !== 1'b0) begin failures++;
      $display("FAIL collide_done got ack=%0d ovf=%b exp 0 0", ak, a_ovf); end
  endtask

  task automatic test_overflow();
    int ta, tk, ak, bn, acks;
    acks = 0;
    do_reset();
    for (int f = 1; f <= 4; f++) begin
      run_frame(1'b1, 1'b0, ta, tk, ak, bn);
      acks += ak;
    end
    checks++; if (acks != 4 || a_valid !== 4'b1111) begin failures++;
      $display("FAIL fill got acks=%0d v=%b exp 4 1111", acks, a_valid); end
    run_frame(1'b1, 1'b0, ta, tk, ak, bn);
    checks++; if (ak != 0 || a_ovf !== 1'b1) begin failures++;
      $display("FAIL full_req got ack=%0d ovf=%b exp 0 1", ak, a_ovf); end
    acks = 0;
    for (int f = 6; f <= 182; f++) begin
      run_frame(1'b0, 1'b0, ta, tk, ak, bn);
      acks += ak;
    end
    checks++; if (acks != 0) begin failures++;
      $display("FAIL full_hold got acks=%0d exp 0", acks); end
    run_frame(1'b0, 1'b0, ta, tk, ak, bn);
    checks++; if (ak != 1 || a_valid !== 4'b1111 || a_x[15:0] !== 16'd180 || a_y[15:0] !== 16'd360) begin failures++;
      $display("FAIL respawn0 got ack=%0d v=%b (%0d,%0d) exp 1 1111 (180,360)", ak, a_valid, a_x[15:0], a_y[15:0]); end
    run_frame(1'b1, 1'b0, ta, tk, ak, bn);
    checks++; if (ak != 1 || a_valid !== 4'b1111) begin failures++;
      $display("FAIL respawn1 got ack=%0d v=%b exp 1 1111", ak, a_valid); end
    run_frame(1'b1, 1'b0, ta, tk, ak, bn);
    checks++; if (ak != 1 || a_x[47:32] !== 16'd180 || a_y[47:32] !== 16'd360) begin failures++;
      $display("FAIL respawn2 got ack=%0d (%0d,%0d) exp 1 (180,360)", ak, a_x[47:32], a_y[47:32]); end
    checks++; if (a_valid !== 4'b1111 || a_x[63:48] !== 16'd65535 || a_y[63:48] !== 16'd541) begin failures++;
      $display("FAIL x_wrap got v=%b (%0d,%0d) exp 1111 (65535,541)", a_valid, a_x[63:48], a_y[63:48]); end
    run_frame(1'b0, 1'b0, ta, tk, ak, bn);
    checks++; if (ak != 0 || a_valid !== 4'b0111 || a_x[63:48] !== 16'd65535 || a_y[63:48] !== 16'd541) begin failures++;
      $display("FAIL x_retire got ack=%0d v=%b (%0d,%0d) exp 0 0111 (65535,541)", ak, a_valid, a_x[63:48], a_y[63:48]); end
  endtask

  initial begin
    test_reset();
    test_spawn_timer();
    test_motion();
    test_retire_y();
    test_inactive();
    test_mid_reset();
    test_busy_drop();
    test_spawn_collide();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
